// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: states, opcodes and
// the select/operation codes driven onto the datapath.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   imm_src_of = IMM_S;
            OP_BEQ:  imm_src_of = IMM_B;
            OP_JAL:  imm_src_of = IMM_J;
            default: imm_src_of = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALUOp plus the instruction's function fields onto
// the ALU operation code.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    // ALU operation select
    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000: begin
                        // op[5] separates R-type sub from addi, whose imm bit 30 is data
                        if (i_op5 && i_funct7b5) begin
                            o_alu_control = ALU_SUB;
                        end else begin
                            o_alu_control = ALU_ADD;
                        end
                    end
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multicycle RV32I datapath through fetch, decode,
// execute, memory and writeback, with PC-enable and immediate-format decode.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       Illegal
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_alu_op;
    logic       w_pc_update;
    logic       w_branch;

    // State register; reset forces FETCH so in-flight writes drop at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH: w_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = EXECR;
                    OP_ITYPE:     w_next = EXECI;
                    OP_JAL:       w_next = JAL;
                    OP_BEQ:       w_next = BEQ;
                    default:      w_next = FETCH;
                endcase
            end
            MEMADR: begin
                if (op[5]) begin
                    w_next = MEMWRITE;
                end else begin
                    w_next = MEMREAD;
                end
            end
            MEMREAD:  w_next = MEMWB;
            MEMWB:    w_next = FETCH;
            MEMWRITE: w_next = FETCH;
            EXECR:    w_next = ALUWB;
            EXECI:    w_next = ALUWB;
            ALUWB:    w_next = FETCH;
            JAL:      w_next = ALUWB;
            BEQ:      w_next = FETCH;
            default:  w_next = FETCH;
        endcase
    end

    // Per-state datapath controls
    always_comb begin
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        w_alu_op    = ALUOP_ADD;
        RegWrite    = 1'b0;
        Illegal     = 1'b0;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        case (r_state)
            FETCH: begin
                IRWrite     = 1'b1;
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALURESULT;
                w_pc_update = 1'b1;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ: Illegal = 1'b0;
                    default: Illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = RES_READDATA;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECR: begin
                ALUSrcA  = SRCA_RS1;
                w_alu_op = ALUOP_FUNCT;
            end
            EXECI: begin
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
            end
            ALUWB: RegWrite = 1'b1;
            JAL: begin
                ALUSrcA     = SRCA_OLDPC;
                ALUSrcB     = SRCB_FOUR;
                w_pc_update = 1'b1;
            end
            BEQ: begin
                ALUSrcA  = SRCA_RS1;
                w_alu_op = ALUOP_SUB;
                w_branch = 1'b1;
            end
            default: begin
                AdrSrc = 1'b0;
            end
        endcase
    end

    assign PCWrite = w_pc_update | (w_branch & Zero);
    assign ImmSrc  = imm_src_of(op);

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_op5         (op[5]),
        .i_funct7b5    (funct7b5),
        .o_alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed and randomized instruction sequences checked cycle by cycle against
// an instruction-timeline model of the controller.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .Illegal    (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ALUControl ImmSrc RegWrite Illegal
    function automatic logic [18:0] pack(input logic pcw, input logic adr, input logic mw, input logic irw,
                                         input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                                         input logic [2:0] alu, input logic [1:0] imm, input logic rw,
                                         input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ill};
    endfunction

    wire [18:0] obs_vec = pack(PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                               ALUControl, ImmSrc, RegWrite, Illegal);

    typedef enum {K_LW, K_SW, K_R, K_I, K_JAL, K_BEQ, K_ILL} kind_t;

    function automatic kind_t classify(input logic [6:0] o);
        if (o == 7'b0000011) return K_LW;
        if (o == 7'b0100011) return K_SW;
        if (o == 7'b0110011) return K_R;
        if (o == 7'b0010011) return K_I;
        if (o == 7'b1101111) return K_JAL;
        if (o == 7'b1100011) return K_BEQ;
        return K_ILL;
    endfunction

    function automatic int cpi(input kind_t k);
        case (k)
            K_LW:    return 5;
            K_SW, K_R, K_I, K_JAL: return 4;
            K_BEQ:   return 3;
            default: return 2;
        endcase
    endfunction

    // ALU operation the instruction's semantics ask for
    function automatic logic [2:0] funct_op(input kind_t k, input logic [2:0] f3, input logic f7);
        if (f3 == 3'b000) return (k == K_R && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    // Expected controls in cycle c (1 = fetch) of an instruction's timeline
    function automatic logic [18:0] expect_vec(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                               input logic z, input int c);
        kind_t      k = classify(o);
        logic [1:0] imm = (k == K_SW) ? 2'b01 : (k == K_BEQ) ? 2'b10 : (k == K_JAL) ? 2'b11 : 2'b00;
        if (c == 1) return pack(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0, 1'b0);
        if (c == 2) return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0, k == K_ILL);
        if (c == 3) begin
            case (k)
                K_LW, K_SW: return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 1'b0, 1'b0);
                K_R:   return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, funct_op(k, f3, f7), imm, 1'b0, 1'b0);
                K_I:   return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, funct_op(k, f3, f7), imm, 1'b0, 1'b0);
                K_JAL: return pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, imm, 1'b0, 1'b0);
                default: return pack(z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, imm, 1'b0, 1'b0);
            endcase
        end
        if (c == 4) begin
            if (k == K_LW) return pack(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0, 1'b0);
            if (k == K_SW) return pack(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0, 1'b0);
            return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b1, 1'b0);
        end
        return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, imm, 1'b1, 1'b0);
    endfunction

    task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    // zmode: 0 random Zero per cycle, 1 Zero held high, 2 Zero held low.
    // abort_at: cycle in which reset is pulsed (0 = run to completion).
    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zmode, input int abort_at);
        int n = cpi(classify(o));
        op = o; funct3 = f3; funct7b5 = f7;
        for (int c = 1; c <= n; c++) begin
            Zero = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("%s_c%0d", tag, c), obs_vec, expect_vec(o, f3, f7, Zero, c));
            if (c == abort_at) begin
                #1 reset = 1'b0;
                #1;
                check({tag, "_rst_memwrite"}, {18'd0, MemWrite}, 19'd0);
                check({tag, "_rst_state"}, obs_vec, expect_vec(o, f3, f7, Zero, 1));
                @(posedge clk);
                #1 check({tag, "_rst_held"}, obs_vec, expect_vec(o, f3, f7, Zero, 1));
                #1 reset = 1'b1;
                #1 check({tag, "_rst_release"}, obs_vec, expect_vec(o, f3, f7, Zero, 1));
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    logic [6:0] op_pool [7];

    initial begin
        op_pool[0] = 7'b0000011; op_pool[1] = 7'b0100011; op_pool[2] = 7'b0110011;
        op_pool[3] = 7'b0010011; op_pool[4] = 7'b1101111; op_pool[5] = 7'b1100011;
        op_pool[6] = 7'b0000000;
        reset = 1'b0; op = 7'b0100011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
        #3 check("reset_outputs", obs_vec, expect_vec(op, funct3, funct7b5, Zero, 1));
        @(posedge clk);
        #2 reset = 1'b1;

        run_instr("lw",        7'b0000011, 3'b010, 1'b0, 0, 0);
        run_instr("sw",        7'b0100011, 3'b010, 1'b0, 0, 0);
        run_instr("sub",       7'b0110011, 3'b000, 1'b1, 0, 0);
        run_instr("addi",      7'b0010011, 3'b000, 1'b1, 0, 0);
        run_instr("beq_taken", 7'b1100011, 3'b000, 1'b0, 1, 0);
        run_instr("beq_not",   7'b1100011, 3'b000, 1'b0, 2, 0);
        run_instr("illegal",   7'b0000000, 3'b000, 1'b0, 0, 0);
        run_instr("jal",       7'b1101111, 3'b000, 1'b0, 0, 0);
        run_instr("sw_abort",  7'b0100011, 3'b010, 1'b0, 0, 4);
        run_instr("post_rst",  7'b0110011, 3'b111, 1'b0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            logic [6:0] o;
            if ($urandom_range(0, 4) == 0) o = 7'($urandom);
            else o = op_pool[$urandom_range(0, 6)];
            run_instr($sformatf("rand%0d", i), o, 3'($urandom), 1'($urandom), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

- Moore-style FSM that sequences a multicycle RV32I datapath: one shared ALU, one unified instruction/data memory port, an instruction register and an OldPC register.
- Decodes the latched instruction fields.
- Each cycle, drives the mux selects, register enables and ALU operation that step the datapath through fetch, decode, execute, memory and writeback.
- Supports lw, sw, R-type ALU, I-type ALU, jal, beq; flags anything else as illegal.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op  in  7  Instr[6:0] from instruction register
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register / OldPC enable
- ResultSrc  out  2  00=ALUOut, 01=ReadData register, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 register
- ALUSrcB  out  2  00=rs2 register, 01=ImmExt, 10=constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- RegWrite  out  1  register file write enable
- Illegal  out  1  one-cycle pulse in Decode on unsupported opcode

## Operation
States and Moore outputs (unlisted enables are 0; unlisted selects are 00):
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCUpdate=1.
  - Next state: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add (branch/jump target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - any other opcode → FETCH, with Illegal=1
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=add.
  - op[5]=0 → MEMREAD; op[5]=1 → MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next state: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state: FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1. Next state: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct. Next state: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct. Next state: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCUpdate=1. Next state: ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, Branch=1. Next state: FETCH.

PC enable:
- PCWrite = PCUpdate | (Branch & Zero).
- This is the only output that depends combinationally on an input other than the instruction fields.

ImmSrc is decoded purely from op, in every state:
- lw / I-ALU → 00
- sw → 01
- beq → 10
- jal → 11
- any other opcode → 00

ALU decoder (ALUOp=funct):
- funct3 000: sub if (op[5] & funct7b5), else add
- funct3 010: slt
- funct3 110: or
- funct3 111: and
- any other funct3: add

## Timing
- State register updates on rising clk edge; all outputs are combinational from state and inputs.
- reset low → asynchronously enters FETCH. Outputs during reset equal FETCH values, with PCWrite=1 and IRWrite=1; the datapath's own reset overrides them.
- Reset asserted mid-instruction aborts it immediately: MemWrite and RegWrite drop in the same cycle, with no partial writeback.
- First FETCH occurs in the first clock edge cycle after reset deasserts.
- Cycles per instruction:
  - lw 5
  - sw 4
  - R-type 4
  - I-type 4
  - jal 4
  - beq 3
  - illegal 2
- Zero is sampled only in BEQ; its value in other states is ignored.
- op, funct3 and funct7b5 are valid from DECODE onward, once IR has been loaded at the end of FETCH.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ
  - opcode constants
  - ALUOp encoding: add=00, sub=01, funct=10
  - ALUControl, ImmSrc, ALUSrcA/B and ResultSrc encodings
- One combinational sub-module, `alu_decoder` (ALUOp, funct3, op[5], funct7b5 → ALUControl).
- The FSM, PCWrite logic and ImmSrc decode live in `multicycle_controller`.

## Test plan
- Reset low mid-MEMWRITE:
  - MemWrite falls within the same cycle, state=FETCH.
  - After release: IRWrite=1, ALUSrcB=10.
- lw (op=0000011) from FETCH → states F,D,MEMADR,MEMREAD,MEMWB.
  - RegWrite=1 only in cycle 5, with ResultSrc=01.
  - ImmSrc=00 throughout.
- sw (op=0100011) → MemWrite=1 only in cycle 4, AdrSrc=1, ImmSrc=01.
- R-type sub (op=0110011, funct3=000, funct7b5=1) → ALUControl=001 in EXECR.
  - Same fields with op=0010011 (addi) → ALUControl=000.
- beq with Zero=1 → PCWrite=1 in cycle 3.
  - With Zero=0 → PCWrite=0 in cycle 3.
  - Next state FETCH in both cases.
- Opcode 0000000 → Illegal=1 for exactly one cycle (DECODE), then FETCH.
  - jal → PCWrite=1 in JAL state, RegWrite=1 in the following ALUWB.
